// File: rtl/c2h_frame_ring_ctrl.sv
// c2h_frame_ring_ctrl: owns the C2H DDR frame ring, issues one write command per frame and tracks full/empty against the host pointer
module c2h_frame_ring_ctrl #(
  parameter int unsigned          ADDR_BITS = 32,
  parameter logic [ADDR_BITS-1:0] BUF_START = 32'h0000_0000,
  parameter logic [ADDR_BITS-1:0] BUF_END   = 32'h1000_0000,
  parameter logic [31:0]          BUF_SIZE  = 32'd2048,
  parameter logic [31:0]          FRM_SIZE  = 32'd2048
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_areset,
  input  logic                 frm_valid,
  output logic                 frm_ready,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [ADDR_BITS-1:0] cmd_addr,
  output logic [31:0]          cmd_len,
  input  logic                 wr_done,
  input  logic                 wr_err,
  input  logic [ADDR_BITS-1:0] c2h_rd_next,
  output logic [ADDR_BITS-1:0] c2h_wr_next,
  output logic                 ring_full,
  output logic                 ring_empty,
  output logic [31:0]          frame_cnt,
  output logic [15:0]          err_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT} state_t;
  state_t                r_state, w_state_nxt;
  logic [ADDR_BITS-1:0]  r_wr, r_rd, r_cmd_addr, w_wr_inc;
  logic [ADDR_BITS:0]    w_sum;
  logic [31:0]           r_frame_cnt;
  logic [15:0]           r_err_cnt;
  logic                  w_accept, w_done, w_err;
  // Extra bit keeps the wrap compare exact even when the ring ends at the top of the address space
  always_comb begin
    w_sum       = {1'b0, r_wr} + (ADDR_BITS+1)'(BUF_SIZE);
    w_wr_inc    = (w_sum >= {1'b0, BUF_END}) ? BUF_START : w_sum[ADDR_BITS-1:0];
    ring_full   = (w_wr_inc == r_rd);
    ring_empty  = (r_wr == r_rd);
    w_accept    = (r_state == S_IDLE) && frm_valid && !ring_full;
    w_err       = (r_state == S_WAIT) && wr_err;
    w_done      = (r_state == S_WAIT) && wr_done && !wr_err;
    w_state_nxt = (r_state == S_IDLE) ? (w_accept ? S_CMD : S_IDLE) :
                  (r_state == S_CMD)  ? (cmd_ready ? S_WAIT : S_CMD) :
                  ((wr_done || wr_err) ? S_IDLE : S_WAIT);
  end
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state     <= S_IDLE;
      r_wr        <= BUF_START;
      r_rd        <= BUF_START;
      r_cmd_addr  <= BUF_START;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rd    <= c2h_rd_next;
      if (w_accept) r_cmd_addr <= r_wr;
      if (w_done) begin
        r_wr        <= w_wr_inc;
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end
      if (w_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end
  assign frm_ready   = w_accept;
  assign cmd_valid   = (r_state == S_CMD);
  assign cmd_addr    = r_cmd_addr;
  assign cmd_len     = FRM_SIZE;
  assign c2h_wr_next = r_wr;
  assign frame_cnt   = r_frame_cnt;
  assign err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_c2h_frame_ring_ctrl.sv
// tb_c2h_frame_ring_ctrl: directed scenarios on a 4-slot ring with hand-computed expectations
module tb_c2h_frame_ring_ctrl;
  logic        clk = 0, rst = 1;
  logic        frm_valid = 0, frm_ready, cmd_valid, cmd_ready = 0;
  logic [31:0] cmd_addr, cmd_len;
  logic        wr_done = 0, wr_err = 0;
  logic [31:0] c2h_rd_next = 0, c2h_wr_next, frame_cnt;
  logic        ring_full, ring_empty;
  logic [15:0] err_cnt;
  int          n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  c2h_frame_ring_ctrl #(
    .ADDR_BITS(32), .BUF_START(32'h0), .BUF_END(32'h2000),
    .BUF_SIZE(32'h800), .FRM_SIZE(32'h400)
  ) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .frm_valid(frm_valid), .frm_ready(frm_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_done(wr_done), .wr_err(wr_err), .c2h_rd_next(c2h_rd_next), .c2h_wr_next(c2h_wr_next),
    .ring_full(ring_full), .ring_empty(ring_empty), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );
  // Stimulus only: waits (bounded) for a command, handshakes it, then pulses done/err a cycle later
  task automatic run_frame(input logic done, input logic err, output logic [31:0] addr, output logic ok);
    ok = 0;
    addr = 32'hDEAD_BEEF;
    frm_valid = 1;
    cmd_ready = 1;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) begin
        ok = 1;
        addr = cmd_addr;
      end
    end
    @(negedge clk);
    @(negedge clk);
    wr_done = done;
    wr_err = err;
    @(negedge clk);
    wr_done = 0;
    wr_err = 0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    n_tests++; if (c2h_wr_next !== 32'h0) begin n_fail++; $display("FAIL reset_wr_next got %h exp 0", c2h_wr_next); end
    n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got %b exp 0", cmd_valid); end
    n_tests++; if (ring_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", ring_empty); end
    n_tests++; if (ring_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", ring_full); end
    n_tests++; if (frame_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    n_tests++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    n_tests++; if (cmd_len !== 32'h400) begin n_fail++; $display("FAIL cmd_len got %h exp 400", cmd_len); end
    rst = 0;
  endtask
  task automatic test_fill;
    logic [31:0] a;
    logic ok;
    for (int k = 0; k < 3; k++) begin
      run_frame(1, 0, a, ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fill_timeout frame %0d got no cmd_valid", k); end
      n_tests++; if (a !== 32'(k * 32'h800)) begin n_fail++; $display("FAIL fill_addr frame %0d got %h exp %h", k, a, k * 32'h800); end
    end
    n_tests++; if (c2h_wr_next !== 32'h1800) begin n_fail++; $display("FAIL fill_wr_next got %h exp 1800", c2h_wr_next); end
    n_tests++; if (ring_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", ring_full); end
    n_tests++; if (frame_cnt !== 32'd3) begin n_fail++; $display("FAIL fill_frame_cnt got %0d exp 3", frame_cnt); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (frm_ready !== 1'b0) begin n_fail++; $display("FAIL stall_frm_ready got %b exp 0", frm_ready); end
      @(negedge clk);
      n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL stall_cmd_valid got %b exp 0", cmd_valid); end
    end
  endtask
  task automatic test_wrap;
    logic [31:0] a;
    logic ok;
    c2h_rd_next = 32'h800;
    n_tests++; if (ring_full !== 1'b1) begin n_fail++; $display("FAIL wrap_full_lag got %b exp 1", ring_full); end
    @(negedge clk);
    n_tests++; if (ring_full !== 1'b0) begin n_fail++; $display("FAIL wrap_full_clear got %b exp 0", ring_full); end
    n_tests++; if (frm_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_frm_ready got %b exp 1", frm_ready); end
    run_frame(1, 0, a, ok);
    frm_valid = 0;
    n_tests++; if (ok !== 1'b1 || a !== 32'h1800) begin n_fail++; $display("FAIL wrap_addr got %h ok %b exp 1800", a, ok); end
    n_tests++; if (c2h_wr_next !== 32'h0) begin n_fail++; $display("FAIL wrap_wr_next got %h exp 0", c2h_wr_next); end
    n_tests++; if (ring_full !== 1'b1) begin n_fail++; $display("FAIL wrap_full_again got %b exp 1", ring_full); end
    n_tests++; if (frame_cnt !== 32'd4) begin n_fail++; $display("FAIL wrap_frame_cnt got %0d exp 4", frame_cnt); end
  endtask
  task automatic test_cmd_stall;
    cmd_ready = 0;
    c2h_rd_next = 32'h0;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (ring_empty !== 1'b1 || ring_full !== 1'b0) begin n_fail++; $display("FAIL empty_state got empty %b full %b exp 1 0", ring_empty, ring_full); end
    wr_done = 1;
    @(negedge clk);
    wr_done = 0;
    n_tests++; if (frame_cnt !== 32'd4) begin n_fail++; $display("FAIL idle_done_ignored got %0d exp 4", frame_cnt); end
    frm_valid = 1;
    @(negedge clk);
    frm_valid = 0;
    n_tests++; if (cmd_valid !== 1'b1 || cmd_addr !== 32'h0) begin n_fail++; $display("FAIL stall_issue got valid %b addr %h exp 1 0", cmd_valid, cmd_addr); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++; if (cmd_valid !== 1'b1 || cmd_addr !== 32'h0) begin n_fail++; $display("FAIL stall_hold cycle %0d got valid %b addr %h exp 1 0", k, cmd_valid, cmd_addr); end
    end
    cmd_ready = 1;
    @(negedge clk);
    n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL stall_handshake got %b exp 0", cmd_valid); end
    wr_done = 1;
    @(negedge clk);
    wr_done = 0;
    n_tests++; if (c2h_wr_next !== 32'h800 || frame_cnt !== 32'd5) begin n_fail++; $display("FAIL stall_done got wr %h cnt %0d exp 800 5", c2h_wr_next, frame_cnt); end
  endtask
  task automatic test_error;
    logic [31:0] a;
    logic ok;
    run_frame(0, 1, a, ok);
    n_tests++; if (ok !== 1'b1 || a !== 32'h800) begin n_fail++; $display("FAIL err_addr got %h ok %b exp 800", a, ok); end
    n_tests++; if (err_cnt !== 16'd1 || c2h_wr_next !== 32'h800) begin n_fail++; $display("FAIL err_first got err %0d wr %h exp 1 800", err_cnt, c2h_wr_next); end
    run_frame(1, 1, a, ok);
    n_tests++; if (ok !== 1'b1 || a !== 32'h800) begin n_fail++; $display("FAIL err_retry_addr got %h ok %b exp 800", a, ok); end
    n_tests++; if (err_cnt !== 16'd2 || c2h_wr_next !== 32'h800 || frame_cnt !== 32'd5) begin n_fail++; $display("FAIL err_both got err %0d wr %h cnt %0d exp 2 800 5", err_cnt, c2h_wr_next, frame_cnt); end
    run_frame(1, 0, a, ok);
    frm_valid = 0;
    n_tests++; if (ok !== 1'b1 || a !== 32'h800) begin n_fail++; $display("FAIL err_recover_addr got %h ok %b exp 800", a, ok); end
    n_tests++; if (c2h_wr_next !== 32'h1000 || frame_cnt !== 32'd6) begin n_fail++; $display("FAIL err_recover got wr %h cnt %0d exp 1000 6", c2h_wr_next, frame_cnt); end
  endtask
  task automatic test_reset_midop;
    frm_valid = 1;
    cmd_ready = 1;
    @(negedge clk);
    frm_valid = 0;
    n_tests++; if (cmd_valid !== 1'b1 || cmd_addr !== 32'h1000) begin n_fail++; $display("FAIL midop_issue got valid %b addr %h exp 1 1000", cmd_valid, cmd_addr); end
    @(negedge clk);
    n_tests++; if (cmd_valid !== 1'b0 || c2h_wr_next !== 32'h1000) begin n_fail++; $display("FAIL midop_wait got valid %b wr %h exp 0 1000", cmd_valid, c2h_wr_next); end
    rst = 1;
    #1;
    n_tests++; if (c2h_wr_next !== 32'h0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL midop_async got wr %h valid %b exp 0 0", c2h_wr_next, cmd_valid); end
    n_tests++; if (frame_cnt !== 32'h0 || err_cnt !== 16'h0) begin n_fail++; $display("FAIL midop_counters got cnt %0d err %0d exp 0 0", frame_cnt, err_cnt); end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    wr_done = 1;
    @(negedge clk);
    wr_done = 0;
    n_tests++; if (frame_cnt !== 32'h0 || c2h_wr_next !== 32'h0 || ring_empty !== 1'b1) begin n_fail++; $display("FAIL late_done got cnt %0d wr %h empty %b exp 0 0 1", frame_cnt, c2h_wr_next, ring_empty); end
    frm_valid = 1;
    cmd_ready = 0;
    @(negedge clk);
    frm_valid = 0;
    n_tests++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL cmd_rst_pre got %b exp 1", cmd_valid); end
    rst = 1;
    #1;
    n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL cmd_rst_async got %b exp 0", cmd_valid); end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL cmd_rst_after got %b exp 0", cmd_valid); end
  endtask
  initial begin
    test_reset;
    test_fill;
    test_wrap;
    test_cmd_stall;
    test_error;
    test_reset_midop;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/c2h_frame_ring_ctrl.md
Name: c2h_frame_ring_ctrl

Overview:
Owns the FPGA-to-host (C2H) DDR frame ring that the AXI-Lite register file advertises to the host. Accepts frame requests from the upstream capture path and issues one write command per frame to the DDR write engine (datamover). On each completed frame it advances the write pointer, wrapping at the ring end. It drives C2H_WR_NEXT into the register file and consumes the host-written C2H_RD_NEXT to detect ring full/empty.

Parameters:
ADDR_BITS, 32, width of ring addresses and pointers
BUF_START, 32'h0000_0000, first byte address of the ring
BUF_END, 32'h1000_0000, first byte address past the ring (exclusive)
BUF_SIZE, 32'd2048, slot stride in bytes
FRM_SIZE, 32'd2048, bytes per frame written into a slot

Ports:
s_axi_aclk  in  1  single clock, shared with the register file
s_axi_areset  in  1  asynchronous, active-high reset
frm_valid  in  1  upstream has a complete frame ready to store
frm_ready  out  1  frame accepted this cycle
cmd_valid  out  1  write command valid to DDR write engine
cmd_ready  in  1  write engine accepts command
cmd_addr  out  ADDR_BITS  DDR start address of the frame
cmd_len  out  32  byte count, always FRM_SIZE
wr_done  in  1  one-cycle pulse: frame fully committed to DDR
wr_err  in  1  one-cycle pulse: frame write failed
c2h_rd_next  in  ADDR_BITS  host read pointer, from register file (C2H_RD_NEXT)
c2h_wr_next  out  ADDR_BITS  next slot FPGA will write, to register file (C2H_WR_NEXT)
ring_full  out  1  next(wr) == rd
ring_empty  out  1  wr == rd
frame_cnt  out  32  frames committed since reset
err_cnt  out  16  failed frame writes since reset, saturating

Behaviour:
- Static requirements: (BUF_END-BUF_START) % BUF_SIZE == 0; FRM_SIZE <= BUF_SIZE; at least 2 slots. Usable capacity is slots-1.
- Reset (async, active-high): state IDLE; c2h_wr_next=BUF_START; rd_q=BUF_START; cmd_valid=0; cmd_addr=BUF_START; frame_cnt=0; err_cnt=0; ring_empty=1; ring_full=0; frm_ready=0.
- rd_q registers c2h_rd_next every cycle. ring_full and ring_empty are combinational from rd_q and c2h_wr_next, so they follow a host pointer update one cycle later.
- next(p) = (p + BUF_SIZE >= BUF_END) ? BUF_START : p + BUF_SIZE. Compute the comparison in ADDR_BITS+1 bits so the sum cannot overflow.
- cmd_len = FRM_SIZE, constant.
- State machine:
  - IDLE: frm_ready = frm_valid & !ring_full (combinational). On acceptance: load cmd_addr=c2h_wr_next, set cmd_valid=1, go to CMD. If ring full, frm_ready=0 and the request stalls; frames are never dropped.
  - CMD: cmd_valid held 1 with cmd_addr stable until cmd_ready. On cmd_valid&cmd_ready: cmd_valid=0, go to WAIT.
  - WAIT: on wr_done: c2h_wr_next=next(c2h_wr_next), frame_cnt+1, go to IDLE. On wr_err: pointer unchanged, err_cnt+1 (saturate at 16'hFFFF), go to IDLE. If both pulse in the same cycle, wr_err wins.
  - wr_done and wr_err outside WAIT are ignored.
- Minimum throughput is 3 cycles per frame: accept, command handshake, then done.
- The host may change c2h_rd_next at any time. Fullness is evaluated only at acceptance in IDLE; an in-flight frame is never cancelled.
- A host pointer outside [BUF_START,BUF_END) or not slot-aligned is not corrected. Full/empty then compare raw values. This is a host error.
- Reset mid-operation: cmd_valid drops immediately and the pointer returns to BUF_START. A late wr_done after reset is ignored because the state is IDLE.

Test Plan:
1. Ring BUF_START=0, BUF_END=0x2000, BUF_SIZE=0x800, FRM_SIZE=0x400 (4 slots). Apply reset -> c2h_wr_next=0, cmd_valid=0, ring_empty=1, ring_full=0, frame_cnt=0.
2. frm_valid held high, cmd_ready=1, wr_done 2 cycles after each command, c2h_rd_next=0 -> cmd_addr 0x0, 0x800, 0x1000 with cmd_len=0x400. c2h_wr_next goes to 0x1800, ring_full=1, 4th request stalls (frm_ready=0), frame_cnt=3.
3. Continue from 2; set c2h_rd_next=0x800 -> ring_full=0 one cycle later. 4th frame gets cmd_addr=0x1800; after wr_done c2h_wr_next wraps to 0x0 and ring_full=1 again.
4. Hold cmd_ready=0 for 5 cycles in CMD -> cmd_valid=1 and cmd_addr unchanged throughout. State advances to WAIT only on the handshake cycle.
5. Pulse wr_err in WAIT at cmd_addr=0x800 -> err_cnt=1, c2h_wr_next stays 0x800, next frame reissues cmd_addr=0x800. Pulse wr_done and wr_err together -> treated as error.
6. Assert s_axi_areset during WAIT with c2h_wr_next=0x1000 -> c2h_wr_next=0, cmd_valid=0 immediately. A wr_done pulse after reset release leaves frame_cnt=0.
